// File: rtl/cla_chunk_sequencer.sv
// W-bit adder built from one external 6-bit cla_adder, reused one chunk per clock.
// LSB chunk first; the carry register threads the chunks together.
module cla_chunk_sequencer #(
    parameter int NCHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*NCHUNK-1:0]   in_a,
    input  logic [6*NCHUNK-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*NCHUNK-1:0]   out_sum,
    output logic                  out_cout,
    output logic [5:0]            add_a,
    output logic [5:0]            add_b,
    output logic                  add_cin,
    input  logic [5:0]            add_s,
    input  logic                  add_cout
);

    localparam int W  = 6 * NCHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic [IW-1:0]   idx_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

    // The adder is combinational, so its inputs must come straight from state.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[6*idx_q +: 6];
            add_b   = b_q[6*idx_q +: 6];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[6*idx_q +: 6] <= add_s;
                    carry_q             <= add_cout;
                    // idx saturates on the last chunk instead of wrapping
                    if (idx_q == LAST) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Scoreboard bench for cla_chunk_sequencer with a behavioural 6-bit adder.
// Inputs driven and outputs sampled on the falling edge.
module tb_cla_chunk_sequencer;

    localparam int NCHUNK = 4;
    localparam int W      = 6 * NCHUNK;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_cin;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_sum;
    logic            out_cout;
    logic [5:0]      add_a;
    logic [5:0]      add_b;
    logic            add_cin;
    logic [5:0]      add_s;
    logic            add_cout;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    assign {add_cout, add_s} = 7'(add_a) + 7'(add_b) + 7'(add_cin);

    cla_chunk_sequencer #(.NCHUNK(NCHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_junk(input int junk);
        if (junk == 1) begin
            in_valid  = 1'($urandom);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_cin    = 1'($urandom);
            out_ready = 1'($urandom);
        end else if (junk == 2) begin
            in_valid = 1'b1;
            in_a     = 24'hAAAAAA;
            in_b     = 24'h555555;
            in_cin   = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Called on a falling edge with the DUT in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int gap, input int hold,
                          input int junk);
        logic [W:0]   snap;
        logic         c;
        logic [5:0]   s;
        logic [5:0]   ca;
        logic [5:0]   cb;
        int           e;
        out_ready = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("in_ready_gap", in_ready, 1);
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
        @(negedge clk);
        c = cin;
        e = 0;
        while (!out_valid && e < 50) begin
            if (e < NCHUNK) begin
                ca = a[6*e +: 6];
                cb = b[6*e +: 6];
                chk("add_a", add_a, ca);
                chk("add_b", add_b, cb);
                chk("add_cin", add_cin, c);
                {c, s} = 7'(ca) + 7'(cb) + 7'(c);
            end
            chk("in_ready_busy", in_ready, 0);
            drive_junk(junk);
            @(negedge clk);
            e++;
        end
        // valid seen after edge e is sampled high on edge e+1
        chk("latency", e + 1, NCHUNK + 1);
        if (!out_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        chk("add_a_done", add_a, 0);
        snap = {out_cout, out_sum};
        out_ready = 1'b0;
        repeat (hold) begin
            drive_junk(junk);
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", {out_cout, out_sum}, snap);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        chk("result", {out_cout, out_sum}, exp_q.pop_front());
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", {out_cout, out_sum}, 0);
        chk("rst_add", {add_a, add_b, add_cin}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", {out_cout, out_sum, out_valid}, 0);

        run_op(24'hFFFFFF, 24'h000001, 1'b0, 0, 0, 0);
        run_op(24'h123456, 24'h654321, 1'b1, 0, 0, 0);
        run_op(24'h000000, 24'h000000, 1'b1, 1, 10, 0);
        run_op(24'h123456, 24'h654321, 1'b1, 0, 0, 2);
        run_op(24'hAAAAAA, 24'h555555, 1'b1, 0, 0, 0);

        in_valid = 1'b1;
        in_a     = 24'h111111;
        in_b     = 24'h222222;
        in_cin   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out", {out_valid, out_cout, out_sum}, 0);
        chk("abort_add", {add_a, add_b, add_cin}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(24'h000010, 24'h000020, 1'b0, 0, 0, 0);

        for (int i = 0; i < 10000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(7) == 0) ? 1 : 0,
                   ($urandom_range(7) == 0) ? int'($urandom_range(3, 1)) : 0,
                   1);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
